// File: rtl/dec_pkg.sv
// Shared types and constants for the one-hot decoder.
//   state_e      : controller states (idle, holding a direct result, scanning)
//   MODE_DIRECT  : mode input value selecting direct binary decode
//   MODE_SCAN    : mode input value selecting autonomous scan
//   MAX_N_OUT    : largest supported output count
//   MAX_DWELL    : largest supported per-step dwell
package dec_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StScan
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned MAX_N_OUT = 256;
  localparam int unsigned MAX_DWELL = 255;

endpackage

// File: rtl/dec_onehot.sv
// Combinational binary-to-one-hot decoder.
//   code_i     : W-bit binary code
//   onehot_o   : N_OUT-bit one-hot image of code_i (all zero if code_i >= N_OUT)
//   in_range_o : high when code_i < N_OUT
module dec_onehot #(
  parameter int unsigned N_OUT = 4,
  parameter int unsigned W     = $clog2(N_OUT)
) (
  input  logic [W-1:0]     code_i,
  output logic [N_OUT-1:0] onehot_o,
  output logic             in_range_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      onehot_o[i] = (int'(code_i) == i);
    end
    in_range_o = (int'(code_i) < int'(N_OUT));
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready handshakes and a scan mode.
// Direct mode decodes sel into a held one-hot result; scan mode walks one hot bit
// across all outputs, presenting each for at least DWELL cycles.
// Optional feature macro: DEC_RANGE_CHK_EN (reject sel >= N_OUT with an err pulse).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   mode          : 0 direct, 1 scan (only acted on in idle)
//   sel/sel_valid/sel_ready : binary select handshake
//   scan_start    : launches a scan from idle in scan mode
//   onehot/onehot_valid/out_ready : registered result handshake
//   busy          : scan in progress
//   err           : one-cycle pulse after an out-of-range sel is rejected
module onehot_decoder_seq
  import dec_pkg::*;
#(
  parameter int unsigned N_OUT = 4,
  parameter int unsigned W     = $clog2(N_OUT),
  parameter int unsigned DWELL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [W-1:0]     sel,
  input  logic             sel_valid,
  output logic             sel_ready,
  input  logic             scan_start,
  output logic [N_OUT-1:0] onehot,
  output logic             onehot_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

`ifdef DEC_RANGE_CHK_EN
  localparam bit RangeChkEn = 1'b1;
`else
  localparam bit RangeChkEn = 1'b0;
`endif

  localparam logic [7:0] DwellLast = 8'(DWELL - 1);

  state_e           state_q;
  logic [W-1:0]     idx_q;
  logic [7:0]       cnt_q;
  logic [N_OUT-1:0] onehot_q;
  logic             valid_q;
  logic             err_q;

  logic [W-1:0]     code;
  logic [N_OUT-1:0] code_oh;
  logic             code_in_range;
  logic             accept;
  logic             reject;
  logic             last_step;

  // One decoder serves both paths: the next scan index while scanning, index 0
  // when a scan may launch from idle, otherwise the incoming select code.
  always_comb begin
    code = sel;
    if (state_q == StScan) begin
      code = idx_q + W'(1);
    end else if ((state_q == StIdle) && (mode == MODE_SCAN)) begin
      code = '0;
    end
  end

  dec_onehot #(
    .N_OUT (N_OUT),
    .W     (W)
  ) u_dec_onehot (
    .code_i     (code),
    .onehot_o   (code_oh),
    .in_range_o (code_in_range)
  );

  assign sel_ready = (mode == MODE_DIRECT) &&
                     ((state_q == StIdle) || ((state_q == StHold) && out_ready));
  assign accept    = sel_valid && sel_ready;
  assign reject    = RangeChkEn && accept && !code_in_range;
  assign last_step = (idx_q == W'(N_OUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= reject;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (!reject) begin
              onehot_q <= code_oh;
              valid_q  <= 1'b1;
              state_q  <= StHold;
            end
          end else if ((mode == MODE_SCAN) && scan_start) begin
            state_q  <= StScan;
            idx_q    <= '0;
            cnt_q    <= DwellLast;
            onehot_q <= code_oh;
            valid_q  <= 1'b1;
          end
        end
        StHold: begin
          // accept implies out_ready here, so a rejected code retires the held
          // result through the out_ready branch and returns to idle.
          if (accept && !reject) begin
            onehot_q <= code_oh;
          end else if (out_ready) begin
            onehot_q <= '0;
            valid_q  <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StScan: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else if (out_ready) begin
            if (last_step) begin
              idx_q    <= '0;
              onehot_q <= '0;
              valid_q  <= 1'b0;
              state_q  <= StIdle;
            end else begin
              idx_q    <= idx_q + W'(1);
              cnt_q    <= DwellLast;
              onehot_q <= code_oh;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          onehot_q <= '0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign onehot       = onehot_q;
  assign onehot_valid = valid_q;
  assign busy         = (state_q == StScan);
  assign err          = err_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
module tb_onehot_decoder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: N_OUT=6, DWELL=2
  logic       a_rst, a_mode, a_sel_valid, a_sel_ready, a_scan_start;
  logic [2:0] a_sel;
  logic [5:0] a_onehot;
  logic       a_onehot_valid, a_out_ready, a_busy, a_err;

  // Instance B: N_OUT=4, DWELL=3
  logic       b_rst, b_mode, b_sel_valid, b_sel_ready, b_scan_start;
  logic [1:0] b_sel;
  logic [3:0] b_onehot;
  logic       b_onehot_valid, b_out_ready, b_busy, b_err;

  onehot_decoder_seq #(
    .N_OUT (6),
    .DWELL (2)
  ) u_dut_a (
    .clk          (clk),
    .rst          (a_rst),
    .mode         (a_mode),
    .sel          (a_sel),
    .sel_valid    (a_sel_valid),
    .sel_ready    (a_sel_ready),
    .scan_start   (a_scan_start),
    .onehot       (a_onehot),
    .onehot_valid (a_onehot_valid),
    .out_ready    (a_out_ready),
    .busy         (a_busy),
    .err          (a_err)
  );

  onehot_decoder_seq #(
    .N_OUT (4),
    .DWELL (3)
  ) u_dut_b (
    .clk          (clk),
    .rst          (b_rst),
    .mode         (b_mode),
    .sel          (b_sel),
    .sel_valid    (b_sel_valid),
    .sel_ready    (b_sel_ready),
    .scan_start   (b_scan_start),
    .onehot       (b_onehot),
    .onehot_valid (b_onehot_valid),
    .out_ready    (b_out_ready),
    .busy         (b_busy),
    .err          (b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    a_rst = 1'b1; a_mode = 1'b0; a_sel = '0; a_sel_valid = 1'b0;
    a_scan_start = 1'b0; a_out_ready = 1'b0;
    b_rst = 1'b1; b_mode = 1'b0; b_sel = '0; b_sel_valid = 1'b0;
    b_scan_start = 1'b0; b_out_ready = 1'b0;
    tick();
    tick();
    a_rst = 1'b0;
    b_rst = 1'b0;
    #1;

    // Reset state
    check("a_rst_onehot", 32'(a_onehot), 32'h0);
    check("a_rst_valid", 32'(a_onehot_valid), 32'h0);
    check("a_rst_busy", 32'(a_busy), 32'h0);
    check("a_rst_err", 32'(a_err), 32'h0);
    check("a_rst_ready", 32'(a_sel_ready), 32'h1);
    check("b_rst_onehot", 32'(b_onehot), 32'h0);

    // Direct decode with backpressure on A: sel=5 held 4 cycles
    a_sel = 3'd5; a_sel_valid = 1'b1;
    #1;
    check("a_dir_ready_idle", 32'(a_sel_ready), 32'h1);
    tick();
    a_sel_valid = 1'b0; a_out_ready = 1'b0;
    #1;
    check("a_dir_oh5", 32'(a_onehot), 32'h20);
    check("a_dir_valid", 32'(a_onehot_valid), 32'h1);
    check("a_dir_ready_stall", 32'(a_sel_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_dir_hold_oh", 32'(a_onehot), 32'h20);
      check("a_dir_hold_valid", 32'(a_onehot_valid), 32'h1);
    end
    a_sel = 3'd2; a_sel_valid = 1'b1; a_out_ready = 1'b1;
    #1;
    check("a_dir_ready_hold", 32'(a_sel_ready), 32'h1);
    tick();
    a_sel_valid = 1'b0;
    check("a_dir_oh2", 32'(a_onehot), 32'h04);
    check("a_dir_valid2", 32'(a_onehot_valid), 32'h1);
    tick();
    check("a_dir_retire_valid", 32'(a_onehot_valid), 32'h0);
    check("a_dir_retire_oh", 32'(a_onehot), 32'h0);

    // Scan mode in idle: sel_valid ignored
    a_mode = 1'b1; a_sel = 3'd1; a_sel_valid = 1'b1;
    #1;
    check("a_scanmode_ready", 32'(a_sel_ready), 32'h0);
    tick();
    check("a_scanmode_ignore", 32'(a_onehot_valid), 32'h0);
    a_sel_valid = 1'b0; a_mode = 1'b0;

    // Out-of-range sel=7 on N_OUT=6
    a_sel = 3'd7; a_sel_valid = 1'b1; a_out_ready = 1'b0;
    #1;
    check("a_rng_ready", 32'(a_sel_ready), 32'h1);
    tick();
    a_sel_valid = 1'b0;
`ifdef DEC_RANGE_CHK_EN
    check("a_rng_err", 32'(a_err), 32'h1);
    check("a_rng_valid", 32'(a_onehot_valid), 32'h0);
    check("a_rng_oh", 32'(a_onehot), 32'h0);
    tick();
    check("a_rng_err_pulse", 32'(a_err), 32'h0);
`else
    check("a_rng_err", 32'(a_err), 32'h0);
    check("a_rng_valid", 32'(a_onehot_valid), 32'h1);
    check("a_rng_oh", 32'(a_onehot), 32'h0);
    a_out_ready = 1'b1;
    tick();
    check("a_rng_retire", 32'(a_onehot_valid), 32'h0);
`endif

    // Scan on A then reset while index 3 is presented
    a_mode = 1'b1; a_scan_start = 1'b1; a_out_ready = 1'b1;
    tick();
    a_scan_start = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      check("a_scan_oh", 32'(a_onehot), 32'(1 << (k / 2)));
      check("a_scan_busy", 32'(a_busy), 32'h1);
      if (k < 6) tick();
    end
    a_rst = 1'b1; a_mode = 1'b0;
    tick();
    a_rst = 1'b0;
    #1;
    check("a_midrst_oh", 32'(a_onehot), 32'h0);
    check("a_midrst_valid", 32'(a_onehot_valid), 32'h0);
    check("a_midrst_busy", 32'(a_busy), 32'h0);
    check("a_midrst_ready", 32'(a_sel_ready), 32'h1);

    // Back-to-back direct on B
    b_out_ready = 1'b1; b_sel_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_sel = 2'(i);
      #1;
      check("b_b2b_ready", 32'(b_sel_ready), 32'h1);
      tick();
      check("b_b2b_oh", 32'(b_onehot), 32'(1 << i));
      check("b_b2b_valid", 32'(b_onehot_valid), 32'h1);
    end
    b_sel_valid = 1'b0;
    tick();
    check("b_b2b_done", 32'(b_onehot_valid), 32'h0);

    // Full scan on B with mode/scan_start toggling during the scan
    b_mode = 1'b1; b_scan_start = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      check("b_scan_oh", 32'(b_onehot), 32'(1 << (k / 3)));
      check("b_scan_busy", 32'(b_busy), 32'h1);
      check("b_scan_ready", 32'(b_sel_ready), 32'h0);
      b_scan_start = k[0];
      b_mode = k[1];
      tick();
    end
    b_mode = 1'b0; b_scan_start = 1'b0;
    #1;
    check("b_scan_end_valid", 32'(b_onehot_valid), 32'h0);
    check("b_scan_end_oh", 32'(b_onehot), 32'h0);
    check("b_scan_end_busy", 32'(b_busy), 32'h0);
    check("b_scan_end_ready", 32'(b_sel_ready), 32'h1);

    // Scan backpressure on B at index 2
    b_mode = 1'b1; b_scan_start = 1'b1;
    tick();
    b_scan_start = 1'b0; b_mode = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("b_bp_oh", 32'(b_onehot), 32'(1 << (k / 3)));
      tick();
    end
    check("b_bp_idx2", 32'(b_onehot), 32'h4);
    b_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_bp_stall", 32'(b_onehot), 32'h4);
    end
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_bp_idx3", 32'(b_onehot), 32'h8);
    end
    tick();
    check("b_bp_end_valid", 32'(b_onehot_valid), 32'h0);
    check("b_bp_end_busy", 32'(b_busy), 32'h0);
    check("b_err_idle", 32'(b_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
